cpu8080_timer_responder: RTL and testbench
==========================================

Name: cpu8080_timer_responder

Overview:
- I/O-mapped bus responder (slave) for the cpu8080 bus master; sits on the same addr/data/readio/writeio/waitr/intr/inta wires as the core.
- Provides a 16-bit programmable down-counter timer with interrupt generation.
- Inserts programmable wait states on every decoded I/O access.
- Supplies an RST opcode on the data bus during interrupt acknowledge.

Parameters:
- BASE_PORT, 8'h40, I/O base port; must be a multiple of 8; decode is addr[7:3] == BASE_PORT[7:3].
- WAIT_CYCLES, 1, clocks of waitr per decoded I/O access (0..15; 0 = no wait states).
- IRQ_VECTOR, 3'd7, RST number; opcode driven during inta = 8'hC7 | (IRQ_VECTOR << 3).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  16  cpu8080 address bus; only addr[7:0] is decoded for I/O.
- data  inout  8  cpu8080 data bus; driven only as specified below, otherwise high-Z.
- readio  input  1  I/O read strobe from the core.
- writeio  input  1  I/O write strobe from the core.
- inta  input  1  interrupt acknowledge from the core.
- waitr  output  1  wait request to the core.
- intr  output  1  interrupt request to the core.

Behaviour:
- Reset (async): all registers 0; waitr=0; intr=0; data high-Z; wait counter 0.
- Register map (offset = addr[2:0]):
  - 0: RELOAD_LO (R/W).
  - 1: RELOAD_HI (R/W).
  - 2: CTRL (R/W): bit0 EN, bit1 IRQ_EN, bit2 AUTO; bits 7:3 read 0.
  - 3: STATUS: bit0 EXPIRED; write 1 clears it.
  - 4: COUNT_LO (read-only snapshot).
  - 5: COUNT_HI (read-only snapshot).
  - 6, 7: read 8'h00, writes ignored.
- Access detect: sel = (readio | writeio) & match. The rising edge of sel starts an access and loads the wait counter with WAIT_CYCLES. waitr=1 while the wait counter != 0; it decrements each clock.
- Reads: data driven with the register value whenever readio & match & !inta, combinationally from the current value.
- COUNT_LO read latches COUNT_HI into a shadow register; the next COUNT_HI read returns the shadow, giving a coherent 16-bit read.
- Writes: committed exactly once per access, on the first clock with writeio & match & wait counter == 0. A committed flag blocks repeats and clears when writeio falls.
- CTRL EN 0->1 write: count <= {RELOAD_HI, RELOAD_LO} on the same edge.
- Timer, each tick while EN=1:
  - If count == 0: EXPIRED <= 1. If IRQ_EN, pending <= 1. If AUTO, count <= reload; else EN <= 0.
  - Otherwise count <= count - 1.
  - Reload 0 with AUTO: expires every tick.
  - Period = reload + 1 ticks.
- intr = pending.
- Interrupt acknowledge: pending clears on the rising edge of inta. While inta=1, data is driven with the RST opcode, regardless of readio/addr.
- Simultaneous events:
  - Expiry and STATUS-clear write on the same edge: EXPIRED stays 1.
  - Expiry and inta rising edge on the same edge: pending stays 1.
  - CTRL write clearing EN and expiry on the same edge: write wins, and no expiry takes effect.
- A mid-access reset drops waitr immediately and discards any uncommitted write.

Optional Feature:
- Macro: CPU8080_TMR_PRESCALE_EN.
- Enabled:
  - Offset 6 becomes PRESCALE (R/W, 8-bit).
  - A tick occurs once every PRESCALE+1 clocks.
  - The prescaler counter resets to 0 on an EN 0->1 write.
- Disabled:
  - A tick occurs every clock.
  - Offset 6 reads 0 and ignores writes.

Test Plan:
- Reset mid-count: reset=1 -> intr=0, waitr=0, data high-Z, all registers read 0 afterwards.
- Wait states (WAIT_CYCLES=3): writeio to 8'h40 with data 8'h05 -> waitr high exactly 3 clocks; RELOAD_LO=8'h05 committed once; readio 8'h40 -> 8'h05.
- One-shot: RELOAD=16'h0004, CTRL=8'h03 -> expiry 5 clocks after the CTRL commit; intr=1; EN reads 0; STATUS=8'h01. inta pulse -> data=8'hFF (IRQ_VECTOR=7) and intr falls. Write STATUS 8'h01 -> reads 8'h00.
- Auto-reload: RELOAD=16'h0002, CTRL=8'h07 -> EXPIRED set every 3 clocks. Expiry coincident with a STATUS clear leaves EXPIRED=1.
- Decode: access to 8'h48 or 8'h3F -> no waitr, data high-Z, no register change. COUNT_LO then COUNT_HI read returns a coherent value while counting.
- With CPU8080_TMR_PRESCALE_EN: PRESCALE=8'h01, RELOAD=16'h0003 one-shot -> expiry after 8 clocks. Without the macro: offset 6 reads 8'h00 after a write of 8'hAA.

Source files
------------

// File: rtl/cpu8080_timer_responder.sv
// I/O-mapped timer responder for the cpu8080 bus: 16-bit down-counter with IRQ, wait states, RST vector.
// Optional tick prescaler on offset 6 is built when CPU8080_TMR_PRESCALE_EN is defined.
module cpu8080_timer_responder #(
  parameter logic [7:0] BASE_PORT   = 8'h40,
  parameter int         WAIT_CYCLES = 1,
  parameter logic [2:0] IRQ_VECTOR  = 3'd7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        readio,
  input  logic        writeio,
  input  logic        inta,
  output logic        waitr,
  output logic        intr
);

  localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];
  localparam logic [7:0] RST_OP  = 8'hC7 | {2'b00, IRQ_VECTOR, 3'b000};

  logic        r_sel_d, r_committed, r_inta_d;
  logic [3:0]  r_wcnt;
  logic [7:0]  r_reload_lo, r_reload_hi, r_shadow_hi;
  logic [15:0] r_count;
  logic        r_en, r_irq_en, r_auto, r_expired, r_pending;
`ifdef CPU8080_TMR_PRESCALE_EN
  logic [7:0]  r_prescale, r_pcnt;
`endif

  logic [2:0]  w_off;
  logic [7:0]  w_din, w_rdata, w_dout;
  logic        w_match, w_sel, w_rise, w_phase, w_wr, w_rd_lo;
  logic        w_tick, w_ctrl_stop, w_run, w_expire, w_inta_rise, w_drive;
  logic        w_unused_addr;

  assign w_unused_addr = &{1'b0, addr[15:8]};
  assign w_off       = addr[2:0];
  assign w_din       = data;
  assign w_match     = (addr[7:3] == BASE_PORT[7:3]);
  assign w_sel       = (readio | writeio) & w_match;
  assign w_rise      = w_sel & ~r_sel_d;
  // Data phase: wait states elapsed, and never the edge that opens the access unless there are no waits.
  assign w_phase     = (r_wcnt == 4'd0) && (r_sel_d || (WAIT_LD == 4'd0));
  assign w_wr        = writeio & w_match & w_phase & ~r_committed;
  assign w_rd_lo     = readio & w_match & ~inta & w_phase & (w_off == 3'd4);
  assign w_inta_rise = inta & ~r_inta_d;

`ifdef CPU8080_TMR_PRESCALE_EN
  assign w_tick = (r_pcnt >= r_prescale);
`else
  assign w_tick = 1'b1;
`endif

  // A CTRL write that drops EN pre-empts this edge's tick entirely.
  assign w_ctrl_stop = w_wr & (w_off == 3'd2) & ~w_din[0];
  assign w_run       = r_en & w_tick & ~w_ctrl_stop;
  assign w_expire    = w_run & (r_count == 16'd0);

  assign waitr = (r_wcnt != 4'd0);
  assign intr  = r_pending;

  always_comb begin
    w_rdata = 8'h00;
    case (w_off)
      3'd0: w_rdata = r_reload_lo;
      3'd1: w_rdata = r_reload_hi;
      3'd2: w_rdata = {5'b0, r_auto, r_irq_en, r_en};
      3'd3: w_rdata = {7'b0, r_expired};
      3'd4: w_rdata = r_count[7:0];
      3'd5: w_rdata = r_shadow_hi;
`ifdef CPU8080_TMR_PRESCALE_EN
      3'd6: w_rdata = r_prescale;
`endif
      default: w_rdata = 8'h00;
    endcase
  end

  assign w_dout  = inta ? RST_OP : w_rdata;
  assign w_drive = ~reset & (inta | (readio & w_match));
  assign data    = w_drive ? w_dout : 8'hzz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel_d     <= 1'b0;
      r_wcnt      <= 4'd0;
      r_committed <= 1'b0;
      r_inta_d    <= 1'b0;
    end else begin
      r_sel_d  <= w_sel;
      r_inta_d <= inta;
      if (w_rise)
        r_wcnt <= WAIT_LD;
      else if (r_wcnt != 4'd0)
        r_wcnt <= r_wcnt - 4'd1;
      if (!writeio)
        r_committed <= 1'b0;
      else if (w_wr)
        r_committed <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reload_lo <= 8'h00;
      r_reload_hi <= 8'h00;
      r_shadow_hi <= 8'h00;
      r_count     <= 16'h0000;
      r_en        <= 1'b0;
      r_irq_en    <= 1'b0;
      r_auto      <= 1'b0;
      r_expired   <= 1'b0;
      r_pending   <= 1'b0;
`ifdef CPU8080_TMR_PRESCALE_EN
      r_prescale  <= 8'h00;
      r_pcnt      <= 8'h00;
`endif
    end else begin
      if (w_inta_rise)
        r_pending <= 1'b0;
      if (w_run) begin
        if (r_count == 16'd0) begin
          r_expired <= 1'b1;
          if (r_irq_en) r_pending <= 1'b1;
          if (r_auto)
            r_count <= {r_reload_hi, r_reload_lo};
          else
            r_en <= 1'b0;
        end else begin
          r_count <= r_count - 16'd1;
        end
      end
`ifdef CPU8080_TMR_PRESCALE_EN
      if (r_en)
        r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
`endif
      // Register writes come after the timer so a CTRL write overrides a one-shot's EN clear.
      if (w_wr) begin
        case (w_off)
          3'd0: r_reload_lo <= w_din;
          3'd1: r_reload_hi <= w_din;
          3'd2: begin
            r_en     <= w_din[0];
            r_irq_en <= w_din[1];
            r_auto   <= w_din[2];
            if (w_din[0] && !r_en) begin
              r_count <= {r_reload_hi, r_reload_lo};
`ifdef CPU8080_TMR_PRESCALE_EN
              r_pcnt  <= 8'd0;
`endif
            end
          end
          3'd3: if (w_din[0] && !w_expire) r_expired <= 1'b0;
`ifdef CPU8080_TMR_PRESCALE_EN
          3'd6: r_prescale <= w_din;
`endif
          default: ;
        endcase
      end
      if (w_rd_lo)
        r_shadow_hi <= r_count[15:8];
    end
  end

endmodule

// File: tb/tb_cpu8080_timer_responder.sv
// Directed bench for cpu8080_timer_responder; read results are checked against a queue of expected bytes.
`timescale 1ns/1ps
module tb_cpu8080_timer_responder;

  logic        clock, reset, readio, writeio, inta;
  logic [15:0] addr;
  logic        tb_oe;
  logic [7:0]  tb_d;
  wire  [7:0]  data;
  logic        waitr, intr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  assign data = tb_oe ? tb_d : 8'hzz;

  cpu8080_timer_responder #(.BASE_PORT(8'h40), .WAIT_CYCLES(3), .IRQ_VECTOR(3'd7)) dut (
    .clock(clock), .reset(reset), .addr(addr), .data(data), .readio(readio),
    .writeio(writeio), .inta(inta), .waitr(waitr), .intr(intr));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the commit edge.
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d, output int waits);
    int n;
    @(negedge clock);
    addr = {8'h00, a}; tb_d = d; tb_oe = 1'b1; writeio = 1'b1;
    waits = 0; n = 0;
    @(negedge clock);
    while (waitr && n < 20) begin waits++; n++; @(negedge clock); end
    chk("wr_timeout", 16'(n < 20), 16'd1);
    @(negedge clock);
    writeio = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input string tag);
    int n;
    logic [7:0] e;
    @(negedge clock);
    addr = {8'h00, a}; tb_oe = 1'b0; readio = 1'b1;
    n = 0;
    @(negedge clock);
    while (waitr && n < 20) begin n++; @(negedge clock); end
    chk("rd_timeout", 16'(n < 20), 16'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    chk(tag, {8'h00, data}, {8'h00, e});
    @(negedge clock);
    readio = 1'b0;
  endtask

  initial begin
    int w;
    logic [15:0] cexp;
    reset = 1'b1; addr = 16'h0000; readio = 1'b0; writeio = 1'b0; inta = 1'b0;
    tb_oe = 1'b0; tb_d = 8'h00;
    repeat (2) @(negedge clock);
    chk("rst_intr", {15'd0, intr}, 16'd0);
    chk("rst_waitr", {15'd0, waitr}, 16'd0);
    addr = 16'h0040; readio = 1'b1; tb_oe = 1'b1; tb_d = 8'h5A;
    #1 chk("rst_bus_free", {8'h00, data}, 16'h005A);
    readio = 1'b0; tb_oe = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // wait states and basic register access
    bus_wr(8'h40, 8'h05, w);
    chk("wait_cycles", 16'(w), 16'd3);
    exp_q.push_back(8'h05); bus_rd(8'h40, "reload_lo");
    exp_q.push_back(8'h00); bus_rd(8'h41, "reload_hi");

    // address decode
    bus_wr(8'h48, 8'h77, w);
    chk("dec48_wait", 16'(w), 16'd0);
    bus_wr(8'h3F, 8'h77, w);
    chk("dec3f_wait", 16'(w), 16'd0);
    exp_q.push_back(8'h05); bus_rd(8'h40, "reload_lo_kept");
    @(negedge clock);
    addr = 16'h0048; readio = 1'b1; tb_oe = 1'b1; tb_d = 8'h5A;
    repeat (2) @(negedge clock);
    chk("dec48_waitr", {15'd0, waitr}, 16'd0);
    chk("dec48_bus_free", {8'h00, data}, 16'h005A);
    readio = 1'b0; tb_oe = 1'b0;

`ifndef CPU8080_TMR_PRESCALE_EN
    bus_wr(8'h46, 8'hAA, w);
    exp_q.push_back(8'h00); bus_rd(8'h46, "off6_ignored");
    exp_q.push_back(8'h00); bus_rd(8'h47, "off7_zero");
`endif

    // one-shot: reload 4 -> expiry on the 5th edge after the CTRL commit
    bus_wr(8'h40, 8'h04, w);
    bus_wr(8'h41, 8'h00, w);
    bus_wr(8'h42, 8'h03, w);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock); chk("oneshot_intr_pre", {15'd0, intr}, 16'd0);
    end
    @(negedge clock); chk("oneshot_intr", {15'd0, intr}, 16'd1);
    exp_q.push_back(8'h01); bus_rd(8'h43, "oneshot_status");
    exp_q.push_back(8'h02); bus_rd(8'h42, "oneshot_en_cleared");
    @(negedge clock); inta = 1'b1;
    @(negedge clock);
    chk("inta_opcode", {8'h00, data}, 16'h00FF);
    chk("inta_intr_clr", {15'd0, intr}, 16'd0);
    inta = 1'b0;
    bus_wr(8'h43, 8'h01, w);
    exp_q.push_back(8'h00); bus_rd(8'h43, "status_cleared");

    // auto-reload period 3 observed through intr and inta
    bus_wr(8'h40, 8'h02, w);
    bus_wr(8'h42, 8'h07, w);
    repeat (2) @(negedge clock);
    chk("auto_intr_pre", {15'd0, intr}, 16'd0);
    @(negedge clock); chk("auto_intr_1", {15'd0, intr}, 16'd1);
    inta = 1'b1;
    @(negedge clock); chk("auto_inta_clr", {15'd0, intr}, 16'd0);
    inta = 1'b0;
    @(negedge clock); chk("auto_intr_gap", {15'd0, intr}, 16'd0);
    @(negedge clock); chk("auto_intr_2", {15'd0, intr}, 16'd1);
    bus_wr(8'h42, 8'h00, w);
    @(negedge clock); inta = 1'b1;
    @(negedge clock); inta = 1'b0;
    bus_wr(8'h43, 8'h01, w);
    chk("auto_stopped_intr", {15'd0, intr}, 16'd0);

    // period 12: STATUS clear lands on the expiry edge, then CTRL stop lands on a later one
    bus_wr(8'h40, 8'h0B, w);
    bus_wr(8'h42, 8'h05, w);
    repeat (6) @(negedge clock);
    bus_wr(8'h43, 8'h01, w);
    exp_q.push_back(8'h01); bus_rd(8'h43, "status_coincident");
    @(negedge clock);
    bus_wr(8'h43, 8'h01, w);
    repeat (5) @(negedge clock);
    bus_wr(8'h42, 8'h00, w);
    exp_q.push_back(8'h00); bus_rd(8'h43, "stop_wins_status");
    exp_q.push_back(8'h00); bus_rd(8'h44, "stop_wins_count");
    exp_q.push_back(8'h00); bus_rd(8'h42, "stop_wins_ctrl");

    // coherent 16-bit read: LO sampled 5 edges after commit, HI read after the high byte rolls
    bus_wr(8'h40, 8'h05, w);
    bus_wr(8'h41, 8'h01, w);
    bus_wr(8'h42, 8'h05, w);
    cexp = 16'h0105 - 16'd5;
    exp_q.push_back(cexp[7:0]); bus_rd(8'h44, "count_lo");
    exp_q.push_back(cexp[15:8]); bus_rd(8'h45, "count_hi_shadow");
    bus_wr(8'h42, 8'h00, w);

`ifdef CPU8080_TMR_PRESCALE_EN
    bus_wr(8'h46, 8'h01, w);
    bus_wr(8'h40, 8'h03, w);
    bus_wr(8'h41, 8'h00, w);
    bus_wr(8'h42, 8'h03, w);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock); chk("presc_intr_pre", {15'd0, intr}, 16'd0);
    end
    @(negedge clock); chk("presc_intr", {15'd0, intr}, 16'd1);
    exp_q.push_back(8'h01); bus_rd(8'h46, "prescale_rd");
    @(negedge clock); inta = 1'b1;
    @(negedge clock); inta = 1'b0;
`endif

    // reset in the middle of counting and of a wait-stated write
    bus_wr(8'h40, 8'h02, w);
    bus_wr(8'h41, 8'h00, w);
    bus_wr(8'h42, 8'h07, w);
    repeat (8) @(negedge clock);
    chk("pre_rst_intr", {15'd0, intr}, 16'd1);
    @(negedge clock);
    addr = 16'h0040; tb_d = 8'h99; tb_oe = 1'b1; writeio = 1'b1;
    @(negedge clock);
    chk("mid_access_waitr", {15'd0, waitr}, 16'd1);
    reset = 1'b1;
    #1;
    chk("rst_waitr_drop", {15'd0, waitr}, 16'd0);
    chk("rst_intr_drop", {15'd0, intr}, 16'd0);
    writeio = 1'b0; tb_oe = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(8'h00);
      bus_rd(8'(8'h40 + i), "post_rst_reg");
    end
    chk("post_rst_intr", {15'd0, intr}, 16'd0);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
